// File: rtl/cfi_pkg.sv
// Shared types and defaults for the CFI alert response stage.
// NR_COMMIT_PORTS and CFI_VLEN mirror ariane_pkg::NR_COMMIT_PORTS and riscv::VLEN.
package cfi_pkg;

  localparam int unsigned NR_COMMIT_PORTS       = 2;
  localparam int unsigned CFI_VLEN              = 64;
  localparam int unsigned CFI_TIMEOUT_DEFAULT   = 1024;
  localparam int unsigned CFI_LOG_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALERT     = 2'd1,
    ESCALATED = 2'd2
  } cfi_state_e;

  typedef struct packed {
    logic [CFI_VLEN-1:0] pc;
  } cfi_log_entry_t;

  function automatic logic [15:0] cfi_sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cfi_log_fifo.sv
// Small violation-PC history FIFO; a push into a full FIFO without a pop is
// dropped and latches a sticky overflow flag.
module cfi_log_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             overflow_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop_i & ~empty_s;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push_s = push_i & (~full_s | do_pop_s);

  // Pointer and sticky overflow state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      if (push_i && !do_push_s) overflow_r <= 1'b1;
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= data_i;
  end

  assign data_o     = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  assign full_o     = full_s;
  assign empty_o    = empty_s;
  assign overflow_o = overflow_r;

endmodule

// File: rtl/cfi_alert_unit.sv
// CFI violation response: capture offending PC, halt commit, raise IRQ, escalate on timeout.
// Optional violation-PC log is built only when CFI_ALERT_LOG_EN is defined.
module cfi_alert_unit
  import cfi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CFI_TIMEOUT_DEFAULT,
  parameter int unsigned LOG_DEPTH      = CFI_LOG_DEPTH_DEFAULT,
  parameter int unsigned PC_W           = CFI_VLEN
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flow_integrity_violated_i,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0][PC_W-1:0]  commit_pc_i,
  input  logic                                  irq_ack_i,
  output logic                                  halt_commit_o,
  output logic                                  irq_o,
  output logic                                  fatal_o,
  output logic [PC_W-1:0]                       captured_pc_o,
  output logic [15:0]                           event_count_o,
  input  logic                                  log_pop_i,
  output logic                                  log_valid_o,
  output logic [PC_W-1:0]                       log_data_o,
  output logic                                  log_overflow_o
);

  localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  cfi_state_e       state_r;
  cfi_state_e       state_next_s;
  logic [TMR_W-1:0] timer_r;
  logic [TMR_W-1:0] timer_next_s;
  logic             capture_s;
  logic [PC_W-1:0]  last_pc_r;
  logic [PC_W-1:0]  captured_pc_r;
  logic             viol_r;
  logic             ev_s;
  logic [15:0]      event_count_r;
  logic             halt_r;
  logic             irq_r;
  logic             fatal_r;
  logic             halt_next_s;
  logic             irq_next_s;
  logic             fatal_next_s;

  assign ev_s = flow_integrity_violated_i & ~viol_r;

  // Track the most recent committed PC; the higher port is younger.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_pc_r <= {PC_W{1'b0}};
    end else if (commit_ack_i[1]) begin
      last_pc_r <= commit_pc_i[1];
    end else if (commit_ack_i[0]) begin
      last_pc_r <= commit_pc_i[0];
    end
  end

  // Edge detect on the sticky flag and saturating event counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      viol_r        <= 1'b0;
      event_count_r <= 16'd0;
    end else begin
      viol_r <= flow_integrity_violated_i;
      if (ev_s) event_count_r <= cfi_sat_inc16(event_count_r);
    end
  end

  // FSM state, escalation timer and captured PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      timer_r       <= {TMR_W{1'b0}};
      captured_pc_r <= {PC_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      timer_r <= timer_next_s;
      if (capture_s) captured_pc_r <= last_pc_r;
    end
  end

  // Next-state logic; an ack on the final timer cycle beats escalation.
  always_comb begin
    state_next_s = state_r;
    timer_next_s = timer_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ev_s) begin
          state_next_s = ALERT;
          timer_next_s = {TMR_W{1'b0}};
          capture_s    = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ALERT: begin
        if (irq_ack_i && ev_s) begin
          state_next_s = ALERT;
          timer_next_s = {TMR_W{1'b0}};
          capture_s    = 1'b1;
        end else if (irq_ack_i) begin
          state_next_s = IDLE;
        end else if (timer_r == TMR_LAST) begin
          state_next_s = ESCALATED;
        end else begin
          timer_next_s = timer_r + TMR_W'(1'b1);
        end
      end
      ESCALATED: begin
        state_next_s = ESCALATED;
      end
      default: begin
        state_next_s = IDLE;
        timer_next_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_r.
  always_comb begin
    halt_next_s  = 1'b0;
    irq_next_s   = 1'b0;
    fatal_next_s = 1'b0;
    case (state_next_s)
      IDLE: begin
        halt_next_s = 1'b0;
      end
      ALERT: begin
        halt_next_s = 1'b1;
        irq_next_s  = 1'b1;
      end
      ESCALATED: begin
        halt_next_s  = 1'b1;
        fatal_next_s = 1'b1;
      end
      default: begin
        halt_next_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halt_r  <= 1'b0;
      irq_r   <= 1'b0;
      fatal_r <= 1'b0;
    end else begin
      halt_r  <= halt_next_s;
      irq_r   <= irq_next_s;
      fatal_r <= fatal_next_s;
    end
  end

  assign halt_commit_o = halt_r;
  assign irq_o         = irq_r;
  assign fatal_o       = fatal_r;
  assign captured_pc_o = captured_pc_r;
  assign event_count_o = event_count_r;

`ifdef CFI_ALERT_LOG_EN
  logic log_empty_s;
  logic log_full_unused_s;

  cfi_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .WIDTH (PC_W)
  ) u_log_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (ev_s),
    .data_i     (last_pc_r),
    .pop_i      (log_pop_i),
    .data_o     (log_data_o),
    .full_o     (log_full_unused_s),
    .empty_o    (log_empty_s),
    .overflow_o (log_overflow_o)
  );

  assign log_valid_o = ~log_empty_s;
`else
  logic unused_log_s;

  assign unused_log_s   = log_pop_i | (LOG_DEPTH == 32'd0);
  assign log_valid_o    = 1'b0;
  assign log_data_o     = {PC_W{1'b0}};
  assign log_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_cfi_alert_unit.sv
// Scoreboard bench for cfi_alert_unit: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_cfi_alert_unit;
  import cfi_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned LD = 4;
  localparam int unsigned PW = 64;
`ifdef CFI_ALERT_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                flag;
  logic [1:0]          ack;
  logic [1:0][PW-1:0]  pc;
  logic                irq_ack;
  logic                pop;
  logic                halt_commit_o;
  logic                irq_o;
  logic                fatal_o;
  logic [PW-1:0]       captured_pc_o;
  logic [15:0]         event_count_o;
  logic                log_valid_o;
  logic [PW-1:0]       log_data_o;
  logic                log_overflow_o;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned cyc;
    logic        irq;
    logic        halt;
    logic        fatal;
    logic [63:0] pc;
    logic [15:0] cnt;
    logic        lv;
    logic [63:0] ld;
    logic        lo;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  cfi_alert_unit #(
    .TIMEOUT_CYCLES (TO),
    .LOG_DEPTH      (LD),
    .PC_W           (PW)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .flow_integrity_violated_i (flag),
    .commit_ack_i              (ack),
    .commit_pc_i               (pc),
    .irq_ack_i                 (irq_ack),
    .halt_commit_o             (halt_commit_o),
    .irq_o                     (irq_o),
    .fatal_o                   (fatal_o),
    .captured_pc_o             (captured_pc_o),
    .event_count_o             (event_count_o),
    .log_pop_i                 (pop),
    .log_valid_o               (log_valid_o),
    .log_data_o                (log_data_o),
    .log_overflow_o            (log_overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic irq, input logic halt,
                            input logic fatal, input logic [63:0] epc,
                            input logic [15:0] cnt, input logic lv,
                            input logic [63:0] ld, input logic lo);
    exp_t e;
    e.cyc   = cyc;
    e.irq   = irq;
    e.halt  = halt;
    e.fatal = fatal;
    e.pc    = epc;
    e.cnt   = cnt;
    e.lv    = LOG_EN ? lv : 1'b0;
    e.ld    = LOG_EN ? ld : 64'h0;
    e.lo    = LOG_EN ? lo : 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cmp(input string nm, input string field, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, field, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "irq",          64'(irq_o),          64'(e.irq));
      cmp(nm, "halt",         64'(halt_commit_o),  64'(e.halt));
      cmp(nm, "fatal",        64'(fatal_o),        64'(e.fatal));
      cmp(nm, "captured_pc",  captured_pc_o,       e.pc);
      cmp(nm, "event_count",  64'(event_count_o),  64'(e.cnt));
      cmp(nm, "log_valid",    64'(log_valid_o),    64'(e.lv));
      cmp(nm, "log_data",     log_data_o,          e.ld);
      cmp(nm, "log_overflow", 64'(log_overflow_o), 64'(e.lo));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flag = 1'b0; ack = 2'b00; pc = '0; irq_ack = 1'b0; pop = 1'b0;
    step(2);
    expect_out("reset", 0, 0, 0, 64'h0, 16'd0, 0, 64'h0, 0);
    step(1); rst = 1'b0; step(1);

    // Single port-0 commit followed by the checker flag.
    pc[0] = 64'h8000_0100; ack = 2'b01; step(1);
    ack = 2'b00; flag = 1'b1; step(1);
    expect_out("a_alert", 1, 1, 0, 64'h8000_0100, 16'd1, 1, 64'h8000_0100, 0);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    expect_out("a_ack", 0, 0, 0, 64'h8000_0100, 16'd1, 1, 64'h8000_0100, 0);
    pop = 1'b1; step(1); pop = 1'b0;
    expect_out("a_pop", 0, 0, 0, 64'h8000_0100, 16'd1, 0, 64'h0, 0);
    flag = 1'b0; step(2);

    // Both ports commit: port 1 is the younger PC.
    pc[0] = 64'h100; pc[1] = 64'h104; ack = 2'b11; step(1);
    ack = 2'b00; flag = 1'b1; step(1);
    expect_out("b_dual", 1, 1, 0, 64'h104, 16'd2, 1, 64'h104, 0);

    // Ack on the final timer cycle wins over escalation.
    step(7);
    expect_out("c_pre_to", 1, 1, 0, 64'h104, 16'd2, 1, 64'h104, 0);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    expect_out("c_ack_to", 0, 0, 0, 64'h104, 16'd2, 1, 64'h104, 0);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    expect_out("c_idle_ack", 0, 0, 0, 64'h104, 16'd2, 1, 64'h104, 0);
    pop = 1'b1; step(1); pop = 1'b0;
    expect_out("c_pop", 0, 0, 0, 64'h104, 16'd2, 0, 64'h0, 0);

    // Six events: fill, push+pop while full, then a dropped push.
    irq_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc[0] = 64'h200 + 64'(4 * i); ack = 2'b01; flag = 1'b0; step(1);
      ack = 2'b00; flag = 1'b1; pop = (i == 4); step(1);
      pop = 1'b0;
      if (i == 5) irq_ack = 1'b0;
      expect_out($sformatf("d_ev%0d", i), 1, 1, 0, 64'h200 + 64'(4 * i), 16'(3 + i),
                 1, (i <= 3) ? 64'h200 : 64'h204, (i == 5));
    end
    for (int j = 0; j < 4; j++) begin
      pop = 1'b1; step(1); pop = 1'b0;
      expect_out($sformatf("d_pop%0d", j), 1, 1, 0, 64'h214, 16'd8,
                 (j < 3), (j < 3) ? 64'h208 + 64'(4 * j) : 64'h0, 1);
    end
    pop = 1'b1; step(1); pop = 1'b0;
    expect_out("d_pop_empty", 1, 1, 0, 64'h214, 16'd8, 0, 64'h0, 1);

    // Asynchronous reset mid-alert while the flag stays high.
    step(1);
    rst = 1'b1; #1;
    expect_out("e_reset", 0, 0, 0, 64'h0, 16'd0, 0, 64'h0, 0);
    step(1); rst = 1'b0; step(1);
    expect_out("e_redetect", 1, 1, 0, 64'h0, 16'd1, 1, 64'h0, 0);

    // No ack: fatal rises exactly TO cycles after irq.
    step(7);
    expect_out("f_pre_to", 1, 1, 0, 64'h0, 16'd1, 1, 64'h0, 0);
    step(1);
    expect_out("f_fatal", 0, 1, 1, 64'h0, 16'd1, 1, 64'h0, 0);
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    expect_out("f_ack_ign", 0, 1, 1, 64'h0, 16'd1, 1, 64'h0, 0);
    flag = 1'b0; step(1); flag = 1'b1; step(2);
    expect_out("f_esc_ev", 0, 1, 1, 64'h0, 16'd2, 1, 64'h0, 0);

    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfi_alert_unit.md
# cfi_alert_unit

Response stage downstream of the commit-stage control-flow-integrity checker. It takes the checker's sticky `flow_integrity_violated` level and the commit-port PCs, and does four things: records the PC of the offending commit, halts further commits, raises an interrupt, and escalates to a fatal alert if software does not acknowledge within a bounded time. An optional log FIFO keeps a short history of violation PCs for the trap handler.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: cycles in ALERT before escalation; must be ≥ 2.
- `LOG_DEPTH`, default 4: log FIFO entries; power of two, ≥ 2.
- `PC_W`, default `riscv::VLEN`: PC width.

Ports:
- `clk_i`  in  1  clock; one clock domain, all logic on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high. Same one clock as above.
- `flow_integrity_violated_i`  in  1  sticky violation level from the CFI checker.
- `commit_ack_i`  in  `NR_COMMIT_PORTS`  per-port commit acknowledge.
- `commit_pc_i`  in  `NR_COMMIT_PORTS` x `PC_W`  PC of each commit port.
- `irq_ack_i`  in  1  single-cycle software acknowledge.
- `halt_commit_o`  out  1  request to commit stage to stop acknowledging.
- `irq_o`  out  1  CFI interrupt.
- `fatal_o`  out  1  sticky escalation alert.
- `captured_pc_o`  out  `PC_W`  PC latched at alert entry.
- `event_count_o`  out  16  saturating count of violation events.
- `log_pop_i`  in  1  pop log head.
- `log_valid_o`  out  1  log non-empty.
- `log_data_o`  out  `PC_W`  log head PC.
- `log_overflow_o`  out  1  sticky, a push was dropped.

## Operation
- `last_pc` register:
  - if `commit_ack_i[1]`, load `commit_pc_i[1]`;
  - else if `commit_ack_i[0]`, load `commit_pc_i[0]`;
  - else hold.
- Event: `ev = flow_integrity_violated_i & ~viol_q`, where `viol_q` is the registered input. A rising edge counts as one event; a held level gives no further events.
- Every event:
  - increments `event_count_o`, saturating at 16'hFFFF;
  - pushes `last_pc` to the log.
- FSM (`cfi_state_e`):
  - IDLE:
    - `ev` → ALERT.
    - On entry to ALERT: `captured_pc_o` ← `last_pc`; timer ← 0.
  - ALERT:
    - `irq_ack_i` and no `ev` → IDLE.
    - `irq_ack_i` and `ev` → stay in ALERT, re-capture `captured_pc_o`, timer ← 0.
    - `ev` without ack → count/log only; no re-capture, timer continues.
    - Timer == `TIMEOUT_CYCLES`-1 with no ack → ESCALATED. Ack wins on that same cycle.
    - Otherwise timer increments.
  - ESCALATED:
    - Terminal until reset.
    - Events are still counted and logged.
    - `irq_ack_i` is ignored.
- Outputs, all registered from state:
  - `halt_commit_o` = state ≠ IDLE.
  - `irq_o` = state == ALERT.
  - `fatal_o` = state == ESCALATED.
- `irq_ack_i` in IDLE is ignored.
- Log FIFO:
  - push on `ev`; pop on `log_pop_i & log_valid_o`;
  - pop on empty is ignored;
  - push while full with no pop: entry dropped, `log_overflow_o` ← 1;
  - push and pop in the same cycle while full: both accepted, no overflow.

## Timing
- Reset values: state IDLE; every output 0; `last_pc`, `viol_q`, timer, counter, and FIFO pointers all 0.
- Reset mid-operation: asynchronous return to reset values. The log is cleared.
- Checker flag rises at cycle t+1 after the violating commit at t. `last_pc` at t+1 holds that commit's PC.
- `ev` at cycle t → at t+1: `irq_o` = `halt_commit_o` = 1, `captured_pc_o` valid, count incremented, `log_valid_o` = 1.
- `fatal_o` rises exactly `TIMEOUT_CYCLES` cycles after `irq_o` rises, provided no ack arrives.
- Ack at cycle t → `irq_o` and `halt_commit_o` low at t+1.
- `log_data_o` shows the head combinationally from FIFO storage. After a pop at t, the next entry is visible at t+1.

## Configuration
- `CFI_ALERT_LOG_EN` defined: log FIFO instantiated as described.
- `CFI_ALERT_LOG_EN` undefined:
  - no FIFO storage;
  - `log_valid_o`, `log_data_o`, `log_overflow_o` tied to 0;
  - `log_pop_i` ignored;
  - ports unchanged; all other behaviour identical.

## Structure
- `cfi_pkg` holds:
  - `cfi_state_e` enum (IDLE, ALERT, ESCALATED);
  - `cfi_log_entry_t` (PC);
  - default constants `CFI_TIMEOUT_DEFAULT`, `CFI_LOG_DEPTH_DEFAULT`.
- `NR_COMMIT_PORTS` comes from `ariane_pkg`.
- One sub-module, `cfi_log_fifo`: parameterised depth/width, push/pop/full/empty/overflow. Instantiated only under `CFI_ALERT_LOG_EN`.

## Test plan
- Commit port0 PC 0x8000_0100 at t, flag rises t+1 → at t+2 `irq_o` = `halt_commit_o` = 1, `captured_pc_o` = 0x8000_0100, `event_count_o` = 1, `log_data_o` = 0x8000_0100.
- Both ports ack (0x100, 0x104) at t, flag rises t+1 → `captured_pc_o` = 0x104.
- Alert, no ack, `TIMEOUT_CYCLES` = 8 → `fatal_o` = 1 exactly 8 cycles after `irq_o`; later `irq_ack_i` keeps `fatal_o` = 1, `halt_commit_o` = 1.
- Alert, ack on the timeout cycle → IDLE, `fatal_o` stays 0; second ack in IDLE ignored.
- Five events (flag toggled), `LOG_DEPTH` = 4, no pops → 4 entries, `log_overflow_o` = 1, `event_count_o` = 5. Full + push + pop same cycle → no overflow.
- Assert `rst_i` mid-ALERT → all outputs 0 asynchronously, log empty. Flag still high after reset → new event detected once.
